lbp_scan_ctrl: RTL and testbench

- Sequencer for the LBP datapath: raster-scans a 128x128 gray image and issues the nine 3x3 neighbour reads for each interior pixel.
- Drives the neighbour-load strobes into the LBP ALU and issues one LBP write per pixel. Border pixels are written as zero.
- Sits between the gray-image memory port and the ALU/write port at the top level; owns gray_req/gray_addr, lbp_valid/lbp_addr and finish.

---
 rtl/lbp_scan_ctrl.sv | 85 ++++++++
 tb/tb_lbp_scan_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/lbp_scan_ctrl.sv
// lbp_scan_ctrl: raster-scans the gray image, issuing nine 3x3 neighbour reads
// per interior pixel and one LBP write per pixel (border pixels written as zero).
module lbp_scan_ctrl #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  output logic              nb_load,
  output logic [3:0]        nb_idx,
  output logic              border,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic              finish
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = ADDR_W - CW;
  localparam logic [RW-1:0] ROW_END = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_END = CW'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] PIX_END = ADDR_W'(IMG_W * IMG_H - 1);
  typedef enum logic [2:0] {IDLE, READ, LAST, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [3:0] idx_q, idx_d, dr, dc;
  function automatic logic inner(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return r != '0 && r != ROW_END && c != '0 && c != COL_END;
  endfunction
  // neighbour offset: row/col shifted by idx/3-1 and idx%3-1
  always_comb begin
    dr = idx_q / 4'd3;
    dc = idx_q % 4'd3;
    gray_req = state_q == READ && gray_ready;
    gray_addr = state_q == READ ? {row_q + RW'(dr) - RW'(1), col_q + CW'(dc) - CW'(1)} : '0;
  end
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (gray_ready) state_d = inner(row_q, col_q) ? READ : WRITE;
      READ: if (gray_ready) begin
        idx_d = idx_q == 4'd8 ? 4'd0 : idx_q + 4'd1;
        state_d = idx_q == 4'd8 ? LAST : READ;
      end
      LAST: state_d = WRITE;
      WRITE: begin
        {row_d, col_d} = {row_q, col_q} + ADDR_W'(1);
        state_d = {row_q, col_q} == PIX_END ? DONE : inner(row_d, col_d) ? READ : WRITE;
      end
      default: state_d = DONE;
    endcase
  end
  // write-side outputs are registered from the next state so they line up with WRITE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      idx_q     <= '0;
      nb_load   <= 1'b0;
      nb_idx    <= '0;
      border    <= 1'b0;
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      finish    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      idx_q     <= idx_d;
      nb_load   <= gray_req;
      nb_idx    <= gray_req ? idx_q : '0;
      border    <= state_d == WRITE && !inner(row_d, col_d);
      lbp_valid <= state_d == WRITE;
      lbp_addr  <= state_d == WRITE ? {row_d, col_d} : '0;
      finish    <= state_d == DONE;
    end
  end
endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// tb_lbp_scan_ctrl: randomized-stall check against a pixel-level scan model,
// plus a full-frame run on a reduced-size instance.
module tb_lbp_scan_ctrl;
  localparam int W = 128, H = 128, AW = 14;
  localparam int SW = 16, SH = 8, SAW = 7;
  localparam int SI = (SH - 2) * (SW - 2);
  localparam int S_EXP_N = SI * 11 + SW * SH - SI;
  logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b0;
  logic gray_req, nb_load, border, lbp_valid, finish;
  logic [AW-1:0] gray_addr, lbp_addr;
  logic [3:0] nb_idx;
  logic s_rst_n = 1'b0, s_rdy = 1'b0;
  logic s_gray_req, s_nb_load, s_border, s_lbp_valid, s_finish;
  logic [SAW-1:0] s_gray_addr, s_lbp_addr;
  logic [3:0] s_nb_idx;
  int checks = 0, fails = 0;
  bit go, gap, pq;
  int p, k, pidx, cyc, t129, lat129, st;
  lbp_scan_ctrl u_dut (
    .clk(clk), .reset(rst_n), .gray_ready(rdy), .gray_req(gray_req), .gray_addr(gray_addr),
    .nb_load(nb_load), .nb_idx(nb_idx), .border(border), .lbp_valid(lbp_valid),
    .lbp_addr(lbp_addr), .finish(finish)
  );
  lbp_scan_ctrl #(.IMG_W(SW), .IMG_H(SH), .ADDR_W(SAW)) u_small (
    .clk(clk), .reset(s_rst_n), .gray_ready(s_rdy), .gray_req(s_gray_req), .gray_addr(s_gray_addr),
    .nb_load(s_nb_load), .nb_idx(s_nb_idx), .border(s_border), .lbp_valid(s_lbp_valid),
    .lbp_addr(s_lbp_addr), .finish(s_finish)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic bit inner(input int px);
    return px / W >= 1 && px / W <= H - 2 && px % W >= 1 && px % W <= W - 2;
  endfunction
  function automatic int rd_addr(input int px, input int n);
    return (px / W + n / 3 - 1) * W + px % W + n % 3 - 1;
  endfunction
  task automatic model_reset();
    go = 0; gap = 0; pq = 0; p = 0; k = 0; pidx = 0; cyc = 0; t129 = -1; lat129 = -1; st = 0;
  endtask
  // one clock: each pixel needs 9 ready cycles of reads, one drain cycle, then its write
  task automatic step(input bit r);
    int e_req, e_addr, e_wr, e_waddr, e_bd, e_fin, cur;
    @(posedge clk);
    #1 rdy = r;
    @(negedge clk);
    cyc++;
    e_req = 0; e_addr = 0; e_wr = 0; e_waddr = 0; e_bd = 0; e_fin = 0; cur = k;
    if (!go) go = r;
    else if (p == W * H) e_fin = 1;
    else if (inner(p) && k < 9) begin
      e_req = int'(r);
      e_addr = rd_addr(p, k);
      if (r) k++;
    end else if (inner(p) && !gap) gap = 1;
    else begin
      e_wr = 1; e_waddr = p; e_bd = int'(!inner(p));
      p++; k = 0; gap = 0;
    end
    if (e_req == 1 && p == 129 && cur == 0) t129 = cyc;
    if (e_wr == 1 && e_waddr == 129) lat129 = cyc - t129;
    chk("gray_req", int'(gray_req), e_req);
    if (e_req == 1) chk("gray_addr", int'(gray_addr), e_addr);
    chk("nb_load", int'(nb_load), int'(pq));
    if (pq) chk("nb_idx", int'(nb_idx), pidx);
    chk("lbp_valid", int'(lbp_valid), e_wr);
    if (e_wr == 1) begin
      chk("lbp_addr", int'(lbp_addr), e_waddr);
      chk("border", int'(border), e_bd);
    end
    chk("finish", int'(finish), e_fin);
    pq = e_req == 1;
    pidx = cur;
  endtask
  task automatic all_zero(input string tag);
    chk(tag, int'({gray_req, gray_addr, nb_load, nb_idx, border, lbp_valid, lbp_addr, finish}), 0);
  endtask
  initial begin
    int n, last_n, last_a, nv, nr, nl;
    model_reset();
    repeat (3) @(negedge clk);
    all_zero("reset_state");
    rst_n = 1'b1;
    // random idle/stall pattern, stall-free through pixel 130
    for (int i = 0; i < 20000 && !(p == 300 && k == 5); i++)
      step((!go || p > 130) ? ($urandom_range(3) != 0) : 1'b1);
    chk("reach_p300", int'(p == 300 && k == 5), 1);
    chk("lat_p129", lat129, 10);
    #2 rst_n = 1'b0;
    rdy = 1'b0;
    #1 all_zero("async_reset");
    repeat (2) @(negedge clk);
    all_zero("reset_hold");
    rst_n = 1'b1;
    model_reset();
    // restart; 3-cycle stall after idx 3 of pixel 129
    for (int i = 0; i < 20000 && p <= 300; i++) begin
      bit r;
      r = !(p == 129 && k == 4 && st < 3);
      if (!r) st++;
      step(r);
    end
    chk("reach_p301", int'(p > 300), 1);
    chk("lat_p129_stall", lat129, 13);
    // full frame on the reduced instance
    @(negedge clk);
    s_rst_n = 1'b1;
    @(posedge clk);
    #1 s_rdy = 1'b1;
    @(negedge clk);
    n = 0; last_n = -1; last_a = -1; nv = 0; nr = 0; nl = 0;
    for (int i = 0; i < 5000 && !s_finish; i++) begin
      @(negedge clk);
      n++;
      if (s_lbp_valid) begin nv++; last_n = n; last_a = int'(s_lbp_addr); end
      if (s_gray_req) nr++;
      if (s_nb_load) nl++;
    end
    chk("frame_finish", int'(s_finish), 1);
    chk("frame_last_cycle", last_n, S_EXP_N);
    chk("frame_last_addr", last_a, SW * SH - 1);
    chk("frame_finish_cycle", n, last_n + 1);
    chk("frame_writes", nv, SW * SH);
    chk("frame_reads", nr, SI * 9);
    chk("frame_loads", nl, SI * 9);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 s_rdy = 1'($urandom_range(1));
      @(negedge clk);
      chk("done_quiet", int'({s_finish, s_gray_req, s_lbp_valid, s_nb_load}), 8);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
